// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the rr_arb_ctrl round-robin arbiter.
// The hold-limit feature of rr_arb_ctrl is enabled by defining ARB_TIMEOUT_EN.
package arb_pkg;
  typedef enum logic {IDLE, GRANT} arb_state_e;
  localparam int N_REQ_DEF = 4;
  localparam int MAX_HOLD_DEF = 16;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner search starting at ptr.
// Rotates the request vector by ptr, picks the lowest set bit, then un-rotates.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int N = N_REQ_DEF,
  localparam int W = idx_w(N)
) (
  input  logic [N-1:0] request,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         found
);
  logic [N-1:0] rot;
  logic [W-1:0] enc;
  int           sum;
  assign found = |request;
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) rot[i] = request[W'((i + int'(ptr)) % N)];
    enc = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) enc = W'(i);
    sum = int'(enc) + int'(ptr);
    winner = W'((sum >= N) ? sum - N : sum);
  end
endmodule

// File: rtl/rr_arb_ctrl.sv
// rr_arb_ctrl: round-robin arbiter with registered one-hot grant and release handshake.
// Define ARB_TIMEOUT_EN to add the MAX_HOLD hold limit and the timeout pulse.
module rr_arb_ctrl
  import arb_pkg::*;
#(
  parameter  int N_REQ    = N_REQ_DEF,
  parameter  int MAX_HOLD = MAX_HOLD_DEF,
  localparam int IW       = idx_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] request,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [IW-1:0]    grant_id,
  output logic             timeout
);
  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    gid_q, gid_d, ptr_q, ptr_d, ptr_nxt, winner;
  logic             found, release_now, force_now, take, leave;

  rr_pick #(.N(N_REQ)) u_pick (
    .request(request),
    .ptr    (ptr_q),
    .winner (winner),
    .found  (found)
  );

  assign release_now = !request[gid_q] || done[gid_q];
  assign ptr_nxt     = (int'(gid_q) == N_REQ - 1) ? '0 : gid_q + 1'b1;
  assign take        = (state_q == IDLE) && found;
  assign leave       = (state_q == GRANT) && (release_now || force_now);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = (state_q == IDLE) ? (found ? GRANT : IDLE) : (leave ? IDLE : GRANT);
  end

  always_comb begin
    grant_d = leave ? '0 : take ? (N_REQ'(1) << winner) : grant_q;
    gid_d   = leave ? '0 : take ? winner : gid_q;
    ptr_d   = leave ? ptr_nxt : ptr_q;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
  assign force_now = cnt_q == HW'(MAX_HOLD - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end
  // a release that coincides with the limit is a normal release, not a timeout
  always_comb begin
    cnt_d = take ? '0 : (state_q == GRANT && !leave && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    to_d  = leave && !release_now;
  end
  assign timeout = to_q;
`else
  assign force_now = 1'b0;
  // constant 0: without the hold limit MAX_HOLD has no effect
  assign timeout = MAX_HOLD < 0;
`endif

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = gid_q;
endmodule
